// File: rtl/tri_st_add_rslt_if.sv
// Handshake and XER bundle between the EX adder, the result stage and writeback.
// The master side drives adder results and consumer readiness; the slave side is the result stage.
interface tri_st_add_rslt_if;
    logic        in_val;
    logic        in_rdy;
    logic [0:63] in_sum;
    logic        in_cout_0;
    logic        in_cout_32;
    logic [1:0]  in_x_sgn;
    logic [1:0]  in_y_sgn;
    logic        in_is64;
    logic        in_rc;
    logic        in_oe;
    logic        in_ca;
    logic        flush;
    logic        xer_wr_val;
    logic [4:0]  xer_wr_data;
    logic        out_val;
    logic        out_rdy;
    logic [0:63] out_rslt;
    logic        out_cr0_val;
    logic [3:0]  out_cr0;
    logic [4:0]  xer_q;

    modport master (
        output in_val, in_sum, in_cout_0, in_cout_32, in_x_sgn, in_y_sgn,
               in_is64, in_rc, in_oe, in_ca, flush, xer_wr_val, xer_wr_data, out_rdy,
        input  in_rdy, out_val, out_rslt, out_cr0_val, out_cr0, xer_q
    );

    modport slave (
        input  in_val, in_sum, in_cout_0, in_cout_32, in_x_sgn, in_y_sgn,
               in_is64, in_rc, in_oe, in_ca, flush, xer_wr_val, xer_wr_data, out_rdy,
        output in_rdy, out_val, out_rslt, out_cr0_val, out_cr0, xer_q
    );
endinterface

// File: rtl/tri_st_add_rslt.sv
// Adder result stage: derives CA/OV flags and CR0, holds architected XER, buffers results in a FIFO.
// Optional same-cycle forwarding on an empty FIFO is enabled by defining TRI_ST_ADD_RSLT_BYPASS_EN.
module tri_st_add_rslt #(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    tri_st_add_rslt_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    generate
        if (DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
            $error("tri_st_add_rslt: DEPTH must be 2 or 4");
        end
    endgenerate

    // {LT,GT,EQ,SO}; the compare width follows is64, word mode looks at sum[32:63] only.
    function automatic logic [3:0] f_cr0(input logic [0:63] sum, input logic is64, input logic so);
        logic msb;
        logic zero;
        msb  = is64 ? sum[0] : sum[32];
        zero = is64 ? (sum == 64'd0) : (sum[32:63] == 32'd0);
        return {msb, ~msb & ~zero, zero, so};
    endfunction

    function automatic logic [4:0] f_xer_upd(input logic [4:0] xer, input logic oe, input logic ov,
                                             input logic ov32, input logic upd_ca, input logic ca,
                                             input logic ca32);
        logic [4:0] r;
        r = xer;
        if (oe) begin
            r[4] = xer[4] | ov;
            r[3] = ov;
            r[1] = ov32;
        end
        if (upd_ca) begin
            r[2] = ca;
            r[0] = ca32;
        end
        return r;
    endfunction

    logic [0:63]      r_sum_p0 [DEPTH];
    logic [DEPTH-1:0] r_ca_p0;
    logic [DEPTH-1:0] r_ca32_p0;
    logic [DEPTH-1:0] r_ov_p0;
    logic [DEPTH-1:0] r_ov32_p0;
    logic [DEPTH-1:0] r_is64_p0;
    logic [DEPTH-1:0] r_rc_p0;
    logic [DEPTH-1:0] r_oe_p0;
    logic [DEPTH-1:0] r_updca_p0;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_cnt;
    logic [4:0]       r_xer;

    logic        w_ov_in;
    logic        w_ov32_in;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_fpop;
    logic        w_vld_p0;
    logic [0:63] w_hd_sum;
    logic        w_hd_ca;
    logic        w_hd_ca32;
    logic        w_hd_ov;
    logic        w_hd_ov32;
    logic        w_hd_is64;
    logic        w_hd_rc;
    logic        w_hd_oe;
    logic        w_hd_updca;
    logic [3:0]  w_cr0;

    assign w_ov_in   = bus.in_cout_0  ^ bus.in_sum[0]  ^ bus.in_x_sgn[1] ^ bus.in_y_sgn[1];
    assign w_ov32_in = bus.in_cout_32 ^ bus.in_sum[32] ^ bus.in_x_sgn[0] ^ bus.in_y_sgn[0];
    assign w_full    = (r_cnt == FULL_CNT);

`ifdef TRI_ST_ADD_RSLT_BYPASS_EN
    logic w_byp;
    assign w_byp    = (r_cnt == '0) && bus.in_val && bus.out_rdy;
    assign w_vld_p0 = (r_cnt != '0) || w_byp;
    assign w_push   = bus.in_val && !w_full && !bus.flush && !w_byp;
    assign w_pop    = w_vld_p0 && bus.out_rdy;
    assign w_fpop   = w_pop && (r_cnt != '0);
`else
    assign w_vld_p0 = (r_cnt != '0);
    assign w_push   = bus.in_val && !w_full && !bus.flush;
    assign w_pop    = w_vld_p0 && bus.out_rdy;
    assign w_fpop   = w_pop;
`endif

    always_comb begin
        w_hd_sum   = r_sum_p0[r_rptr];
        w_hd_ca    = r_ca_p0[r_rptr];
        w_hd_ca32  = r_ca32_p0[r_rptr];
        w_hd_ov    = r_ov_p0[r_rptr];
        w_hd_ov32  = r_ov32_p0[r_rptr];
        w_hd_is64  = r_is64_p0[r_rptr];
        w_hd_rc    = r_rc_p0[r_rptr];
        w_hd_oe    = r_oe_p0[r_rptr];
        w_hd_updca = r_updca_p0[r_rptr];
`ifdef TRI_ST_ADD_RSLT_BYPASS_EN
        if (w_byp) begin
            w_hd_sum   = bus.in_sum;
            w_hd_ca    = bus.in_cout_0;
            w_hd_ca32  = bus.in_cout_32;
            w_hd_ov    = w_ov_in;
            w_hd_ov32  = w_ov32_in;
            w_hd_is64  = bus.in_is64;
            w_hd_rc    = bus.in_rc;
            w_hd_oe    = bus.in_oe;
            w_hd_updca = bus.in_ca;
        end
`endif
    end

    assign w_cr0 = f_cr0(w_hd_sum, w_hd_is64, r_xer[4] | (w_hd_oe & w_hd_ov));

    // FIFO control: flush clears occupancy; a retiring pop in the same cycle still updates XER below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (bus.flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_fpop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_fpop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Stage p0: entry storage, qualified by occupancy so no reset is needed on the data.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sum_p0[r_wptr]   <= bus.in_sum;
            r_ca_p0[r_wptr]    <= bus.in_cout_0;
            r_ca32_p0[r_wptr]  <= bus.in_cout_32;
            r_ov_p0[r_wptr]    <= w_ov_in;
            r_ov32_p0[r_wptr]  <= w_ov32_in;
            r_is64_p0[r_wptr]  <= bus.in_is64;
            r_rc_p0[r_wptr]    <= bus.in_rc;
            r_oe_p0[r_wptr]    <= bus.in_oe;
            r_updca_p0[r_wptr] <= bus.in_ca;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xer <= '0;
        end else if (bus.xer_wr_val) begin
            r_xer <= bus.xer_wr_data;
        end else if (w_pop) begin
            r_xer <= f_xer_upd(r_xer, w_hd_oe, w_hd_ov, w_hd_ov32, w_hd_updca, w_hd_ca, w_hd_ca32);
        end
    end

    assign bus.in_rdy      = !w_full;
    assign bus.out_val     = w_vld_p0;
    assign bus.out_rslt    = w_vld_p0 ? w_hd_sum : 64'd0;
    assign bus.out_cr0     = w_vld_p0 ? w_cr0 : 4'd0;
    assign bus.out_cr0_val = w_vld_p0 & w_hd_rc;
    assign bus.xer_q       = r_xer;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(bus.in_val && w_full));

endmodule
